sar_scheduler: RTL and testbench

Conversion scheduler for the 8-bit SAR ADC. It shares the single `sarlogic` engine between `NREQ` requesters using round-robin arbitration. It also inserts trim calibrations at power-up, on software request, and every `RECAL_PERIOD` conversions. It sits between the digital requesters and the SAR control logic: it drives `en`/`cal` and consumes `valid`/`result`.

---
 rtl/sar_sched_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/sar_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_sar_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_sched_pkg.sv
// Shared types and constants for the SAR conversion scheduler.
package sar_sched_pkg;

  typedef enum logic [1:0] {
    STARTUP,
    ARB,
    WAIT,
    DELIVER
  } sched_state_t;

  localparam int SAR_BITS       = 8;
  localparam int CONV_LAT       = 10;
  localparam int CAL_LAT        = 44;
  localparam int STARTUP_CYCLES = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot winner, pointer advances past
// the winner when the grant is taken.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_grant_en,
  output logic [NREQ-1:0] o_grant,
  output logic            o_any
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW-1:0] w_idx;

  // Scan from the pointer upward with wrap; first requester found wins.
  always_comb begin
    o_grant   = '0;
    o_any     = 1'b0;
    w_ptr_nxt = r_ptr;
    w_idx     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_idx = PW'((32'(r_ptr) + i) % NREQ);
      if (!o_any && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_any          = 1'b1;
        w_ptr_nxt      = (w_idx == LAST_IDX) ? '0 : w_idx + PW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ptr <= '0;
    end else if (i_grant_en) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/sar_scheduler.sv
// Shares one SAR engine between NREQ requesters (round robin) and inserts
// trim calibrations at power-up, on software request and every RECAL_PERIOD conversions.
module sar_scheduler
  import sar_sched_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int RECAL_PERIOD = 256,
  parameter int TIMEOUT      = 64
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NREQ-1:0]     req,
  output logic [NREQ-1:0]     ack,
  output logic [SAR_BITS-1:0] dout,
  input  logic                cal_req,
  output logic                cal_done,
  output logic                busy,
  output logic                timeout_err,
  output logic                sar_en,
  output logic                sar_cal,
  input  logic                sar_valid,
  input  logic [SAR_BITS-1:0] sar_result
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [15:0]   RECAL_CNT    = 16'(RECAL_PERIOD);
  localparam logic [TW-1:0] TIMEOUT_CNT  = TW'(TIMEOUT);
  localparam logic [1:0]    STARTUP_LAST = 2'(STARTUP_CYCLES - 1);

  sched_state_t        r_state, w_state_nxt;
  logic [1:0]          r_start_cnt, w_start_cnt_nxt;
  logic                r_cal_pending, w_cal_pending_nxt;
  logic [15:0]         r_conv_cnt, w_conv_cnt_nxt, w_conv_cnt_inc;
  logic [TW-1:0]       r_wait_cnt, w_wait_cnt_nxt;
  logic                r_is_cal, w_is_cal_nxt;
  logic [NREQ-1:0]     r_winner, w_winner_nxt;
  logic [NREQ-1:0]     r_ack, w_ack_nxt;
  logic [SAR_BITS-1:0] r_dout, w_dout_nxt;
  logic                r_cal_done, w_cal_done_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_timeout_err, w_timeout_err_nxt;
  logic                r_sar_en, w_sar_en_nxt;
  logic                r_sar_cal, w_sar_cal_nxt;

  logic                w_grant_en;
  logic                w_arb_any;
  logic [NREQ-1:0]     w_arb_grant;
  logic [NREQ-1:0]     w_arb_req;
  logic                w_recal_hit;
  logic                w_cal_end;

  // The requester being acked this cycle is not yet asking again.
  assign w_arb_req = req & ~r_ack;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_req      (w_arb_req),
    .i_grant_en (w_grant_en),
    .o_grant    (w_arb_grant),
    .o_any      (w_arb_any)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_start_cnt_nxt   = r_start_cnt;
    w_cal_pending_nxt = r_cal_pending;
    w_conv_cnt_nxt    = r_conv_cnt;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_is_cal_nxt      = r_is_cal;
    w_winner_nxt      = r_winner;
    w_ack_nxt         = '0;
    w_dout_nxt        = r_dout;
    w_cal_done_nxt    = 1'b0;
    w_timeout_err_nxt = r_timeout_err;
    w_sar_en_nxt      = 1'b0;
    w_sar_cal_nxt     = 1'b0;
    w_grant_en        = 1'b0;
    w_cal_end         = 1'b0;

    w_conv_cnt_inc = (r_conv_cnt == RECAL_CNT) ? r_conv_cnt : r_conv_cnt + 16'd1;
    w_recal_hit    = (r_state == DELIVER) && (w_conv_cnt_inc == RECAL_CNT);

    case (r_state)
      STARTUP: begin
        w_start_cnt_nxt = r_start_cnt + 2'd1;
        if (r_start_cnt == STARTUP_LAST) begin
          w_state_nxt = ARB;
        end
      end
      WAIT: begin
        w_wait_cnt_nxt = r_wait_cnt + TW'(1);
        if (sar_valid || (r_wait_cnt == TIMEOUT_CNT)) begin
          if (!sar_valid) begin
            w_timeout_err_nxt = 1'b1;
          end
          if (r_is_cal) begin
            w_cal_done_nxt = sar_valid;
            w_cal_end      = 1'b1;
            if (!sar_valid) begin
              w_cal_pending_nxt = 1'b1;
            end
            w_state_nxt = ARB;
          end else begin
            w_ack_nxt   = r_winner;
            w_dout_nxt  = sar_valid ? sar_result : '0;
            w_state_nxt = DELIVER;
          end
        end
      end
      DELIVER: begin
        w_conv_cnt_nxt = w_conv_cnt_inc;
        w_state_nxt    = ARB;
        if (w_recal_hit) begin
          w_cal_pending_nxt = 1'b1;
        end
      end
      default: begin
      end
    endcase

    // DELIVER also arbitrates so back-to-back conversions cost 12 cycles;
    // the recal look-ahead keeps the counter-triggered calibration in front.
    if ((r_state == ARB) || (r_state == DELIVER)) begin
      if (r_cal_pending || w_recal_hit) begin
        w_sar_en_nxt      = 1'b1;
        w_sar_cal_nxt     = 1'b1;
        w_is_cal_nxt      = 1'b1;
        w_cal_pending_nxt = 1'b0;
        w_conv_cnt_nxt    = '0;
        w_wait_cnt_nxt    = '0;
        w_state_nxt       = WAIT;
      end else if (w_arb_any) begin
        w_sar_en_nxt   = 1'b1;
        w_is_cal_nxt   = 1'b0;
        w_winner_nxt   = w_arb_grant;
        w_grant_en     = 1'b1;
        w_wait_cnt_nxt = '0;
        w_state_nxt    = WAIT;
      end
    end

    if (cal_req) begin
      w_cal_pending_nxt = 1'b1;
    end

    w_busy_nxt = (w_state_nxt == WAIT) || (w_state_nxt == DELIVER) || w_cal_end;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= STARTUP;
      r_start_cnt   <= '0;
      r_cal_pending <= 1'b1;
      r_conv_cnt    <= '0;
      r_wait_cnt    <= '0;
      r_is_cal      <= 1'b0;
      r_winner      <= '0;
      r_ack         <= '0;
      r_dout        <= '0;
      r_cal_done    <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_sar_en      <= 1'b0;
      r_sar_cal     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_start_cnt   <= w_start_cnt_nxt;
      r_cal_pending <= w_cal_pending_nxt;
      r_conv_cnt    <= w_conv_cnt_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_is_cal      <= w_is_cal_nxt;
      r_winner      <= w_winner_nxt;
      r_ack         <= w_ack_nxt;
      r_dout        <= w_dout_nxt;
      r_cal_done    <= w_cal_done_nxt;
      r_busy        <= w_busy_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_sar_en      <= w_sar_en_nxt;
      r_sar_cal     <= w_sar_cal_nxt;
    end
  end

  assign ack         = r_ack;
  assign dout        = r_dout;
  assign cal_done    = r_cal_done;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign sar_en      = r_sar_en;
  assign sar_cal     = r_sar_cal;

endmodule

// File: tb/tb_sar_scheduler.sv
// Directed bench for sar_scheduler with a behavioural SAR engine model.
module tb_sar_scheduler;
  import sar_sched_pkg::*;

  logic       clk;
  logic       rstn;
  logic [3:0] req, ack, req_rc, ack_rc;
  logic [7:0] dout, dout_rc;
  logic       cal_req, cal_done, busy, timeout_err, sar_en, sar_cal, sar_valid;
  logic       cal_req_rc, cal_done_rc, busy_rc, timeout_err_rc, sar_en_rc, sar_cal_rc, sar_valid_rc;
  logic [7:0] sar_result, sar_result_rc;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // SAR model controls, written only by the main sequence
  bit         m_stall  = 1'b0;
  int         m_inj_lo = -10;
  int         m_inj_hi = -10;
  logic [7:0] m_data    = 8'h00;
  logic [7:0] m_data_rc = 8'h00;

  sar_scheduler #(.NREQ(4), .RECAL_PERIOD(256), .TIMEOUT(64)) u_dut (
    .clk(clk), .rstn(rstn), .req(req), .ack(ack), .dout(dout), .cal_req(cal_req),
    .cal_done(cal_done), .busy(busy), .timeout_err(timeout_err), .sar_en(sar_en),
    .sar_cal(sar_cal), .sar_valid(sar_valid), .sar_result(sar_result)
  );

  sar_scheduler #(.NREQ(4), .RECAL_PERIOD(3), .TIMEOUT(64)) u_rc (
    .clk(clk), .rstn(rstn), .req(req_rc), .ack(ack_rc), .dout(dout_rc), .cal_req(cal_req_rc),
    .cal_done(cal_done_rc), .busy(busy_rc), .timeout_err(timeout_err_rc), .sar_en(sar_en_rc),
    .sar_cal(sar_cal_rc), .sar_valid(sar_valid_rc), .sar_result(sar_result_rc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // SAR engines: valid CONV_LAT / CAL_LAT cycles after the en cycle
  initial begin
    int cnt, cnt_rc;
    cnt = 0; cnt_rc = 0;
    sar_valid = 1'b0; sar_result = 8'h00;
    sar_valid_rc = 1'b0; sar_result_rc = 8'h00;
    forever begin
      @(negedge clk);
      sar_valid    = 1'b0;
      sar_valid_rc = 1'b0;
      if (!rstn) begin
        cnt = 0; cnt_rc = 0;
      end else begin
        if (cnt > 0) begin
          cnt = cnt - 1;
          if (cnt == 0) begin sar_valid = 1'b1; sar_result = m_data; end
        end
        if (cnt_rc > 0) begin
          cnt_rc = cnt_rc - 1;
          if (cnt_rc == 0) begin sar_valid_rc = 1'b1; sar_result_rc = m_data_rc; end
        end
        if (cyc >= m_inj_lo && cyc <= m_inj_hi) begin
          sar_valid = 1'b1; sar_result = 8'hEE;
        end
        if (sar_en && !m_stall) cnt = sar_cal ? CAL_LAT : CONV_LAT;
        if (sar_en_rc) cnt_rc = sar_cal_rc ? CAL_LAT : CONV_LAT;
      end
    end
  end

  // Waits up to 'bound' negedges for an event; n = negedges waited, -1 on expiry.
  // kind: 0 sar_en, 1 ack, 2 cal_done (main); 3 sar_en, 4 ack, 5 cal_done (recal DUT)
  task automatic wait_evt(input int kind, input int bound, output int n, output bit saw_ack);
    bit hit;
    n = -1;
    saw_ack = 1'b0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (ack != 4'b0000) saw_ack = 1'b1;
      case (kind)
        0:       hit = sar_en;
        1:       hit = (ack != 4'b0000);
        2:       hit = cal_done;
        3:       hit = sar_en_rc;
        4:       hit = (ack_rc != 4'b0000);
        default: hit = cal_done_rc;
      endcase
      if (hit) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic reset_quiet();
    int n;
    bit sa;
    @(negedge clk);
    rstn = 1'b0; req = '0; req_rc = '0; m_stall = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_evt(2, 80, n, sa);
  endtask

  task automatic test_reset();
    int n;
    bit sa;
    @(negedge clk);
    rstn = 1'b0; req = '0; req_rc = '0;
    #1;
    checks++;
    if ({ack, dout, cal_done, busy, timeout_err, sar_en, sar_cal} !== 17'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0", {ack, dout, cal_done, busy, timeout_err, sar_en, sar_cal});
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_evt(0, 10, n, sa);
    checks++;
    if (n !== 3) begin failures++; $display("FAIL startup_cal_en: got %0d required 3", n); end
    checks++;
    if (sar_cal !== 1'b1) begin failures++; $display("FAIL startup_sar_cal: got %b required 1", sar_cal); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_on_en: got %b required 1", busy); end
    wait_evt(2, 60, n, sa);
    checks++;
    if (n !== 45) begin failures++; $display("FAIL startup_cal_done: got %0d required 45", n); end
    checks++;
    if (sa !== 1'b0) begin failures++; $display("FAIL no_ack_during_cal: got %b required 0", sa); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_cal_done_cycle: got %b required 1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_idle: got %b required 0", busy); end
  endtask

  task automatic test_single_req();
    int n;
    bit sa;
    m_data = 8'hA5;
    req = 4'b0100;
    wait_evt(0, 5, n, sa);
    checks++;
    if (n !== 1) begin failures++; $display("FAIL req_to_en: got %0d required 1", n); end
    checks++;
    if (sar_cal !== 1'b0) begin failures++; $display("FAIL conv_sar_cal: got %b required 0", sar_cal); end
    wait_evt(1, 20, n, sa);
    checks++;
    if (n !== 11) begin failures++; $display("FAIL ack_latency: got %0d required 11", n); end
    checks++;
    if (ack !== 4'b0100) begin failures++; $display("FAIL ack_value: got %b required 0100", ack); end
    checks++;
    if (dout !== 8'hA5) begin failures++; $display("FAIL dout_value: got %h required a5", dout); end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0000) begin failures++; $display("FAIL ack_pulse: got %b required 0000", ack); end
    checks++;
    if (dout !== 8'hA5) begin failures++; $display("FAIL dout_hold: got %h required a5", dout); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_after_deliver: got %b required 0", busy); end
  endtask

  task automatic test_round_robin();
    int n_en, n_ack;
    bit sa;
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset_quiet();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_evt(0, 15, n_en, sa);
      m_data = 8'h30 + 8'(k);
      checks++;
      if (k > 0 && (n_ack + n_en) !== 12) begin
        failures++; $display("FAIL rr_spacing[%0d]: got %0d required 12", k, n_ack + n_en);
      end
      checks++;
      if (k == 0 && n_en !== 1) begin failures++; $display("FAIL rr_first_en: got %0d required 1", n_en); end
      wait_evt(1, 20, n_ack, sa);
      checks++;
      if (ack !== exp_g[k]) begin failures++; $display("FAIL rr_grant[%0d]: got %b required %b", k, ack, exp_g[k]); end
      checks++;
      if (dout !== m_data) begin failures++; $display("FAIL rr_dout[%0d]: got %h required %h", k, dout, m_data); end
      if (k == 4) req = 4'b0000;
    end
  endtask

  task automatic test_recal();
    int n;
    bit sa;
    bit         exp_cal [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] exp_g   [5] = '{4'b0001, 4'b0010, 4'b0001, 4'b0000, 4'b0010};
    req_rc = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      wait_evt(3, 15, n, sa);
      m_data_rc = 8'h50 + 8'(k);
      checks++;
      if (n !== 1) begin failures++; $display("FAIL recal_en_gap[%0d]: got %0d required 1", k, n); end
      checks++;
      if (sar_cal_rc !== exp_cal[k]) begin
        failures++; $display("FAIL recal_kind[%0d]: got %b required %b", k, sar_cal_rc, exp_cal[k]);
      end
      if (exp_cal[k]) begin
        wait_evt(5, 60, n, sa);
        checks++;
        if (n !== 45) begin failures++; $display("FAIL recal_done: got %0d required 45", n); end
      end else begin
        wait_evt(4, 20, n, sa);
        checks++;
        if (ack_rc !== exp_g[k] || dout_rc !== m_data_rc) begin
          failures++; $display("FAIL recal_ack[%0d]: got %b/%h required %b/%h", k, ack_rc, dout_rc, exp_g[k], m_data_rc);
        end
      end
    end
    req_rc = 4'b0000;
  endtask

  task automatic test_timeout();
    int n;
    bit sa;
    m_stall = 1'b1;
    req = 4'b0010;
    wait_evt(0, 5, n, sa);
    wait_evt(1, 80, n, sa);
    checks++;
    if (n !== 65) begin failures++; $display("FAIL timeout_ack_latency: got %0d required 65", n); end
    checks++;
    if (ack !== 4'b0010) begin failures++; $display("FAIL timeout_ack: got %b required 0010", ack); end
    checks++;
    if (dout !== 8'h00) begin failures++; $display("FAIL timeout_dout: got %h required 00", dout); end
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_err_set: got %b required 1", timeout_err); end
    req = 4'b0000;
    m_stall = 1'b0;
    repeat (5) @(negedge clk);
    m_data = 8'h3C;
    req = 4'b0001;
    wait_evt(0, 5, n, sa);
    wait_evt(1, 20, n, sa);
    req = 4'b0000;
    checks++;
    if (n !== 11 || ack !== 4'b0001 || dout !== 8'h3C) begin
      failures++; $display("FAIL post_timeout_conv: got %0d/%b/%h required 11/0001/3c", n, ack, dout);
    end
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %b required 1", timeout_err); end
  endtask

  task automatic test_cal_req();
    int n;
    bit sa;
    @(negedge clk);
    cal_req = 1'b1;
    @(negedge clk);
    cal_req = 1'b0;
    wait_evt(0, 5, n, sa);
    checks++;
    if (n !== 1 || sar_cal !== 1'b1) begin
      failures++; $display("FAIL cal_req_issue: got %0d/%b required 1/1", n, sar_cal);
    end
    repeat (5) @(negedge clk);
    cal_req = 1'b1;
    @(negedge clk);
    cal_req = 1'b0;
    wait_evt(2, 60, n, sa);
    checks++;
    if (n !== 39) begin failures++; $display("FAIL cal_req_done: got %0d required 39", n); end
    wait_evt(0, 5, n, sa);
    checks++;
    if (n !== 1 || sar_cal !== 1'b1) begin
      failures++; $display("FAIL cal_req_latched_again: got %0d/%b required 1/1", n, sar_cal);
    end
    wait_evt(2, 60, n, sa);
    checks++;
    if (n !== 45) begin failures++; $display("FAIL cal_req_second_done: got %0d required 45", n); end
  endtask

  task automatic test_reset_midwait();
    int n;
    bit sa;
    m_data = 8'h77;
    req = 4'b1000;
    wait_evt(0, 5, n, sa);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    req = 4'b0000;
    #1;
    checks++;
    if ({ack, dout, cal_done, busy, timeout_err, sar_en, sar_cal} !== 17'h0) begin
      failures++;
      $display("FAIL midwait_reset_outputs: got %h required 0", {ack, dout, cal_done, busy, timeout_err, sar_en, sar_cal});
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    m_inj_lo = cyc + 1;
    m_inj_hi = cyc + 2;
    wait_evt(0, 10, n, sa);
    checks++;
    if (n !== 3 || sar_cal !== 1'b1) begin
      failures++; $display("FAIL midwait_restart_cal: got %0d/%b required 3/1", n, sar_cal);
    end
    wait_evt(2, 60, n, sa);
    checks++;
    if (n !== 45 || sa !== 1'b0) begin
      failures++; $display("FAIL midwait_stale_valid: got %0d/%b required 45/0", n, sa);
    end
  endtask

  initial begin
    rstn = 1'b0;
    req = '0; req_rc = '0;
    cal_req = 1'b0; cal_req_rc = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_req();
    test_round_robin();
    test_recal();
    test_timeout();
    test_cal_req();
    test_reset_midwait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
